// File: rtl/rc4_stream_ctrl.sv
// ---------------------------------------------------------------------------
// rc4_stream_ctrl
//
// Session controller for an RC4 keystream core. It accepts a key/message
// configuration, keeps the core in reset between sessions and releases and
// starts it for each session. Keystream bytes go into a small FIFO. Each FIFO
// byte is XORed with one input data byte and sent to a single-register output
// stage. When the message completes or the FIFO overflows, the core returns to
// reset.
//
// Optional feature macro: RC4_DROP_EN
//   When defined, the first DROP_N keystream bytes of every session are
//   discarded before the FIFO (RC4-drop[n]). When undefined, DROP_N is ignored.
//
// Parameters:
//   KS_DEPTH   keystream FIFO depth, power of two in 4..64
//   DROP_N     keystream bytes discarded per session (RC4_DROP_EN only)
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cfg_valid/cfg_ready           configuration handshake
//   cfg_key/cfg_key_len/cfg_msg_len  key, key length (1..4), message length
//   core_rst_n, core_start        core control (core reset is active low)
//   core_key, core_key_length     registered copies of the accepted config
//   core_ks_byte, core_ks_valid   keystream byte strobe from the core
//   din_valid/din_ready/din_data  input byte handshake
//   dout_valid/dout_ready/dout_data/dout_last  output byte handshake
//   busy                          controller is not idle
//   err_len                       one-cycle pulse when a config is rejected
//   err_ovf                       sticky keystream overflow flag
// ---------------------------------------------------------------------------
module rc4_stream_ctrl #(
    parameter int KS_DEPTH = 8,
    parameter int DROP_N   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [31:0] cfg_key,
    input  logic [7:0]  cfg_key_len,
    input  logic [15:0] cfg_msg_len,
    output logic        core_rst_n,
    output logic        core_start,
    output logic [31:0] core_key,
    output logic [7:0]  core_key_length,
    input  logic [7:0]  core_ks_byte,
    input  logic        core_ks_valid,
    input  logic        din_valid,
    output logic        din_ready,
    input  logic [7:0]  din_data,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic [7:0]  dout_data,
    output logic        dout_last,
    output logic        busy,
    output logic        err_len,
    output logic        err_ovf
);

    localparam int AW = $clog2(KS_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    // Parameter sanity checks, evaluated at elaboration.
    if (KS_DEPTH < 4 || KS_DEPTH > 64 || (KS_DEPTH & (KS_DEPTH - 1)) != 0) begin : g_bad_ks_depth
        $error("rc4_stream_ctrl: KS_DEPTH must be a power of two in 4..64");
    end
    if (DROP_N < 0 || DROP_N > 255) begin : g_bad_drop_n
        $error("rc4_stream_ctrl: DROP_N must be in 0..255");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    state_t      state;
    logic [7:0]  fifo_mem [KS_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [15:0] msg_len;
    logic [15:0] ks_cnt;
    logic [15:0] out_cnt;

    logic        fifo_empty;
    logic        fifo_full;
    logic [7:0]  fifo_head;
    logic        cfg_legal;
    logic        drop_done;
    logic        ks_accept;
    logic        out_room;
    logic        load;
    logic        overflow;
    logic        push;
    logic        final_accept;

    // The pointers carry one extra wrap bit so that full and empty can be told apart.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fifo_head  = fifo_mem[rd_ptr[AW-1:0]];

    assign cfg_legal = (cfg_key_len != 8'd0) && (cfg_key_len <= 8'd4) && (cfg_msg_len != 16'd0);

`ifdef RC4_DROP_EN
    logic [7:0] drop_cnt;
    assign drop_done = (drop_cnt >= 8'(DROP_N));
`else
    assign drop_done = 1'b1;
`endif

    // Keystream bytes beyond the message length are dropped silently.
    assign ks_accept = (state == RUN) && core_ks_valid && drop_done && (ks_cnt < msg_len);

    // The output register may be refilled when it is empty or is being drained.
    assign out_room     = !dout_valid || dout_ready;
    assign din_ready    = (state == RUN) && !fifo_empty && out_room && (out_cnt < msg_len);
    assign load         = din_valid && din_ready;

    // A simultaneous pop frees a slot, so a push into a full FIFO is not an overflow.
    assign overflow     = ks_accept && fifo_full && !load;
    assign push         = ks_accept && !overflow;
    assign final_accept = dout_valid && dout_ready && dout_last;

    assign cfg_ready  = (state == IDLE);
    assign core_rst_n = (state == RUN);
    assign core_start = (state == RUN);
    assign busy       = (state != IDLE);

    // FIFO storage. It has no reset because the pointers determine which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= core_ks_byte;
        end
    end

    // Session FSM together with the FIFO pointers, counters and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            core_key        <= 32'd0;
            core_key_length <= 8'd0;
            msg_len         <= 16'd0;
            ks_cnt          <= 16'd0;
            out_cnt         <= 16'd0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            dout_valid      <= 1'b0;
            dout_data       <= 8'd0;
            dout_last       <= 1'b0;
            err_len         <= 1'b0;
            err_ovf         <= 1'b0;
`ifdef RC4_DROP_EN
            drop_cnt        <= 8'd0;
`endif
        end else begin
            err_len <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        if (cfg_legal) begin
                            core_key        <= cfg_key;
                            core_key_length <= cfg_key_len;
                            msg_len         <= cfg_msg_len;
                            ks_cnt          <= 16'd0;
                            out_cnt         <= 16'd0;
                            wr_ptr          <= '0;
                            rd_ptr          <= '0;
                            err_ovf         <= 1'b0;
`ifdef RC4_DROP_EN
                            drop_cnt        <= 8'd0;
`endif
                            state           <= RUN;
                        end else begin
                            err_len <= 1'b1;
                        end
                    end
                end

                RUN: begin
`ifdef RC4_DROP_EN
                    if (core_ks_valid && !drop_done) begin
                        drop_cnt <= drop_cnt + 8'd1;
                    end
`endif
                    if (push) begin
                        wr_ptr <= wr_ptr + PTR_ONE;
                        ks_cnt <= ks_cnt + 16'd1;
                    end

                    if (load) begin
                        rd_ptr     <= rd_ptr + PTR_ONE;
                        out_cnt    <= out_cnt + 16'd1;
                        dout_valid <= 1'b1;
                        dout_data  <= din_data ^ fifo_head;
                        dout_last  <= (out_cnt == msg_len - 16'd1);
                    end else if (dout_valid && dout_ready) begin
                        dout_valid <= 1'b0;
                        dout_last  <= 1'b0;
                    end

                    // When an overflow occurs, the session is abandoned and any pending output byte is dropped.
                    if (overflow) begin
                        err_ovf    <= 1'b1;
                        dout_valid <= 1'b0;
                        dout_last  <= 1'b0;
                        state      <= FLUSH;
                    end else if (final_accept) begin
                        state <= FLUSH;
                    end
                end

                FLUSH: begin
                    wr_ptr     <= '0;
                    rd_ptr     <= '0;
                    dout_valid <= 1'b0;
                    dout_last  <= 1'b0;
                    state      <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
